mlp_layer_seq: RTL and testbench
================================

MLP_LAYER_SEQ -- requirements
Module: mlp_layer_seq

Interface
REQ-001 SHALL have parameter N_IN, default 21, number of input features.
REQ-002 SHALL have parameter N_OUT, default 3, number of neurons; N_OUT >= 2.
REQ-003 SHALL have parameter IN_W, default 4, unsigned feature width.
REQ-004 SHALL have parameter W_W, default 8, signed two's-complement weight width.
REQ-005 SHALL have parameter B_W, default 16, signed bias width.
REQ-006 SHALL have parameter ACC_W, default 32, signed accumulator and activation width.
REQ-007 SHALL have parameter RELU, default 1; 1 = ReLU on every neuron, 0 = linear.
REQ-008 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-009 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-010 SHALL have port in_valid  input  1  feature vector offered.
REQ-011 SHALL have port in_ready  output  1  block can accept a vector.
REQ-012 SHALL have port inp  input  N_IN*IN_W  features; feature k at bits [k*IN_W +: IN_W].
REQ-013 SHALL have port weights  input  N_OUT*N_IN*W_W  weight of neuron n, feature k at [(n*N_IN+k)*W_W +: W_W]; static, not registered.
REQ-014 SHALL have port bias  input  N_OUT*B_W  bias of neuron n at [n*B_W +: B_W]; static, not registered.
REQ-015 SHALL have port out_valid  output  1  result available.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port out_act  output  N_OUT*ACC_W  activation of neuron n at [n*ACC_W +: ACC_W].
REQ-018 SHALL have port out_class  output  max(1,$clog2(N_OUT))  argmax index.

Function
REQ-019 SHALL implement FSM states IDLE, MAC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-020 SHALL accept in IDLE when in_valid & in_ready: register inp, set neuron n=0, feature k=0, acc=sign-extended bias[0], go to MAC.
REQ-021 SHALL in each MAC cycle form product = {1'b0,feature k} (signed) * weight[n][k] and compute s = acc + sign-extended product, ACC_W two's-complement wrap.
REQ-022 SHALL, when k < N_IN-1, store acc=s and increment k.
REQ-023 SHALL, when k == N_IN-1, write act[n] = (RELU && s<0) ? 0 : s; update argmax; if n < N_OUT-1 then n++, k=0, acc=bias[n+1]; else go to DONE.
REQ-024 SHALL perform argmax as signed compare against running best; replace only on strictly greater; neuron 0 seeds best; ties resolve to the lowest index.
REQ-025 SHALL assert out_valid exactly N_IN*N_OUT+1 cycles after the accept edge (cycle T accept -> out_valid at T+N_IN*N_OUT+1).
REQ-026 SHALL hold out_act and out_class stable while out_valid=1 and out_ready=0, indefinitely.
REQ-027 SHALL on out_valid & out_ready return to IDLE; next accept is possible the following cycle, not the same cycle.
REQ-028 SHALL ignore in_valid and inp changes while not in IDLE; weights/bias SHALL be held stable by the user from accept to out_valid.
REQ-029 SHALL keep out_act/out_class of the last completed transaction visible while in IDLE/MAC (out_valid=0 qualifies them).

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE, clear n, k, acc, out_act, out_class and best; in_ready=1, out_valid=0 on the next cycle.
REQ-031 SHALL on reset mid-MAC or mid-DONE discard the transaction with no residual effect on the next one.
REQ-032 SHALL give rst priority over all simultaneous handshake events.

Verification
REQ-033 SHALL pass: defaults, weights = [[0,0,2,-3,-1,-4,-1,0,-5,1,3,1,-1,1,-1,2,-3,2,-4,2,-3],[34,-23,4,-19,11,-19,41,56,19,30,35,-1,-30,-36,-73,63,-89,-36,-50,60,-12],[11,68,-17,16,5,33,7,-30,-25,-25,27,58,13,-52,-27,1,39,-93,-17,-22,-9]], bias=[-73,748,1077], inp all 0, accept at T -> out_valid at T+64, out_act=[0,748,1077], out_class=2.
REQ-034 SHALL pass: same weights/bias, RELU=0, all features 15 -> out_act[0] = -253 (32-bit two's complement), out_valid at T+64.
REQ-035 SHALL pass: all weights 0, bias=[-5,-5,-5], RELU=1 -> out_act=[0,0,0], out_class=0 (tie rule).
REQ-036 SHALL pass: out_ready held 0 for 10 cycles after out_valid -> outputs unchanged, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-037 SHALL pass: rst pulsed at T+20 of a transaction -> in_ready=1, out_valid=0 next cycle; new REQ-033 vector then yields identical REQ-033 results at +64.

Source files
------------

// File: rtl/mlp_layer_seq.sv
// Sequential fully-connected layer: one MAC per cycle over N_OUT neurons x N_IN features, optional ReLU, argmax.
// Latency: out_valid rises N_IN*N_OUT+1 cycles after the accept cycle; one vector in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, then IDLE the next cycle.
//
// Ports:
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    - feature-vector handshake; inp is captured on accept
//   inp                  - N_IN unsigned features, feature k at [k*IN_W +: IN_W]
//   weights, bias        - static signed parameters, held stable by the user for the whole transaction
//   out_valid/out_ready  - result handshake
//   out_act, out_class   - per-neuron activations and argmax index (last completed transaction)
module mlp_layer_seq #(
    parameter int N_IN  = 21,
    parameter int N_OUT = 3,
    parameter int IN_W  = 4,
    parameter int W_W   = 8,
    parameter int B_W   = 16,
    parameter int ACC_W = 32,
    parameter int RELU  = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [N_IN*IN_W-1:0]                         inp,
    input  logic [N_OUT*N_IN*W_W-1:0]                    weights,
    input  logic [N_OUT*B_W-1:0]                         bias,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [N_OUT*ACC_W-1:0]                       out_act,
    output logic [((N_OUT > 2) ? $clog2(N_OUT) : 1)-1:0] out_class
);

    localparam int CLS_W = (N_OUT > 2) ? $clog2(N_OUT) : 1;
    localparam int KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int P_W   = IN_W + 1 + W_W;

    localparam logic [KW-1:0]    K_LAST = KW'(N_IN - 1);
    localparam logic [CLS_W-1:0] N_LAST = CLS_W'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    logic [N_IN*IN_W-1:0]     inp_r;
    logic [CLS_W-1:0]         n;
    logic [KW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  best;
    logic [CLS_W-1:0]         best_idx;
    // Working activations; out_act is only updated when the whole layer is finished
    // so the previous result stays visible during MAC.
    logic [N_OUT*ACC_W-1:0]   act_w;

    logic [IN_W-1:0]          feat;
    logic signed [W_W-1:0]    wgt;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  s;
    logic signed [ACC_W-1:0]  act_new;
    logic                     better;
    logic [CLS_W-1:0]         n_next;
    logic signed [ACC_W-1:0]  bias_first;
    logic signed [ACC_W-1:0]  bias_next;
    logic [N_OUT*ACC_W-1:0]   act_fin;

    always_comb begin
        feat       = inp_r[int'(k)*IN_W +: IN_W];
        wgt        = weights[(int'(n)*N_IN + int'(k))*W_W +: W_W];
        // Feature is unsigned: prepend a zero so the signed multiply treats it as non-negative.
        prod       = P_W'($signed({1'b0, feat})) * P_W'(wgt);
        s          = acc + ACC_W'(prod);
        act_new    = ((RELU != 0) && (s < 0)) ? '0 : s;
        // Neuron 0 always seeds the running best; later neurons win only when strictly greater,
        // so ties stay with the lowest index.
        better     = (n == '0) || (act_new > best);
        n_next     = (n == N_LAST) ? '0 : n + CLS_W'(1);
        bias_first = ACC_W'($signed(bias[B_W-1:0]));
        bias_next  = ACC_W'($signed(bias[int'(n_next)*B_W +: B_W]));
        act_fin    = act_w;
        act_fin[int'(n)*ACC_W +: ACC_W] = act_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            inp_r     <= '0;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            best      <= '0;
            best_idx  <= '0;
            act_w     <= '0;
            out_act   <= '0;
            out_class <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        inp_r    <= inp;
                        n        <= '0;
                        k        <= '0;
                        acc      <= bias_first;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (k == K_LAST) begin
                        act_w[int'(n)*ACC_W +: ACC_W] <= act_new;
                        if (better) begin
                            best     <= act_new;
                            best_idx <= n;
                        end
                        if (n == N_LAST) begin
                            out_act   <= act_fin;
                            out_class <= better ? n : best_idx;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            n   <= n_next;
                            k   <= '0;
                            acc <= bias_next;
                        end
                    end else begin
                        acc <= s;
                        k   <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_seq.sv
// Testbench for mlp_layer_seq: one ReLU instance and one linear instance driven in lockstep.
// Checks fixed vectors, latency, backpressure hold, reset abort and random vectors against a reference model.
// Backpressure is exercised by holding out_ready low while pulsing in_valid with garbage inputs.
module tb_mlp_layer_seq;

    localparam int N_IN  = 21;
    localparam int N_OUT = 3;
    localparam int IN_W  = 4;
    localparam int W_W   = 8;
    localparam int B_W   = 16;
    localparam int ACC_W = 32;
    localparam int LAT   = N_IN * N_OUT + 1;

    localparam int IV_W  = N_IN * IN_W;
    localparam int WV_W  = N_OUT * N_IN * W_W;
    localparam int BV_W  = N_OUT * B_W;
    localparam int AV_W  = N_OUT * ACC_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [IV_W-1:0] inp;
    logic [WV_W-1:0] weights;
    logic [BV_W-1:0] bias;
    logic            out_ready;

    logic            in_ready_r, out_valid_r, in_ready_l, out_valid_l;
    logic [AV_W-1:0] out_act_r, out_act_l;
    logic [1:0]      out_class_r, out_class_l;

    int checks   = 0;
    int failures = 0;

    logic [AV_W-1:0] prev_r, prev_l;
    logic [1:0]      prev_cr, prev_cl;

    int spec_w [N_OUT][N_IN];

    always #5 clk = ~clk;

    mlp_layer_seq #(.RELU(1)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .inp(inp),
        .weights(weights), .bias(bias), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_act(out_act_r), .out_class(out_class_r)
    );

    mlp_layer_seq #(.RELU(0)) dut_lin (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .inp(inp),
        .weights(weights), .bias(bias), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_act(out_act_l), .out_class(out_class_l)
    );

    typedef struct {
        string           name;
        logic [IV_W-1:0] iv;
        logic [WV_W-1:0] wv;
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] exp_r;
        logic [1:0]      cls_r;
        logic [AV_W-1:0] exp_l;
        logic [1:0]      cls_l;
        int              hold;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [AV_W-1:0] pk3(input int a0, input int a1, input int a2);
        logic [AV_W-1:0] r;
        r[0*ACC_W +: ACC_W] = a0;
        r[1*ACC_W +: ACC_W] = a1;
        r[2*ACC_W +: ACC_W] = a2;
        return r;
    endfunction

    function automatic logic [BV_W-1:0] pb3(input int b0, input int b1, input int b2);
        logic [BV_W-1:0] r;
        r[0*B_W +: B_W] = B_W'(b0);
        r[1*B_W +: B_W] = B_W'(b1);
        r[2*B_W +: B_W] = B_W'(b2);
        return r;
    endfunction

    function automatic logic [WV_W-1:0] pack_w(input int w [N_OUT][N_IN]);
        logic [WV_W-1:0] r;
        for (int n = 0; n < N_OUT; n++)
            for (int k = 0; k < N_IN; k++)
                r[(n*N_IN + k)*W_W +: W_W] = W_W'(w[n][k]);
        return r;
    endfunction

    // Reference: plain dot product in 64-bit integers, reduced to 32-bit two's complement at the end.
    function automatic void model(input logic [IV_W-1:0] iv, input logic [WV_W-1:0] wv,
                                  input logic [BV_W-1:0] bv, input bit relu,
                                  output logic [AV_W-1:0] act_v, output logic [1:0] cls);
        int     a [N_OUT];
        longint sum;
        int     best;
        for (int n = 0; n < N_OUT; n++) begin
            sum = longint'($signed(bv[n*B_W +: B_W]));
            for (int k = 0; k < N_IN; k++)
                sum += longint'(iv[k*IN_W +: IN_W]) * longint'($signed(wv[(n*N_IN + k)*W_W +: W_W]));
            a[n] = int'(sum);
            if (relu && a[n] < 0) a[n] = 0;
        end
        best = 0;
        for (int n = 1; n < N_OUT; n++)
            if (a[n] > a[best]) best = n;
        act_v = pk3(a[0], a[1], a[2]);
        cls   = 2'(best);
    endfunction

    task automatic run_txn(input string nm, input logic [IV_W-1:0] iv, input logic [WV_W-1:0] wv,
                           input logic [BV_W-1:0] bv, input logic [AV_W-1:0] er, input logic [1:0] cr,
                           input logic [AV_W-1:0] el, input logic [1:0] cl, input int hold);
        int j;
        int bad;
        @(negedge clk);
        inp      = iv;
        weights  = wv;
        bias     = bv;
        in_valid = 1'b1;
        chk({nm, "_in_ready"}, {in_ready_r, in_ready_l}, 2'b11);
        @(posedge clk);
        j = 0;
        forever begin
            @(negedge clk);
            // Garbage on the input side while busy must be ignored.
            in_valid = 1'($urandom);
            inp      = IV_W'({$urandom, $urandom, $urandom});
            if (j == 10) begin
                chk({nm, "_mac_flags"}, {in_ready_r, out_valid_r, in_ready_l, out_valid_l}, 4'b0000);
                chk({nm, "_mac_prev_act"}, {out_act_r, out_class_r, out_act_l, out_class_l},
                    {prev_r, prev_cr, prev_l, prev_cl});
            end
            if (out_valid_r || j >= 4 * LAT) break;
            @(posedge clk);
            j++;
        end
        chk({nm, "_latency"}, j + 1, LAT);
        chk({nm, "_lin_valid"}, out_valid_l, 1'b1);
        chk({nm, "_act_relu"}, out_act_r, er);
        chk({nm, "_cls_relu"}, out_class_r, cr);
        chk({nm, "_act_lin"}, out_act_l, el);
        chk({nm, "_cls_lin"}, out_class_l, cl);
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            inp       = IV_W'({$urandom, $urandom, $urandom});
            @(posedge clk);
            @(negedge clk);
            if (out_act_r !== er || out_class_r !== cr || out_act_l !== el || out_class_l !== cl ||
                out_valid_r !== 1'b1 || out_valid_l !== 1'b1 || in_ready_r !== 1'b0 || in_ready_l !== 1'b0)
                bad++;
        end
        if (hold > 0) chk({nm, "_hold_bad_cycles"}, bad, 0);
        // Release with in_valid high: must return to IDLE, not accept in the same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({nm, "_release"}, {in_ready_r, out_valid_r, in_ready_l, out_valid_l}, 4'b1010);
        chk({nm, "_idle_keep"}, {out_act_r, out_class_r, out_act_l, out_class_l}, {er, cr, el, cl});
        prev_r  = er;
        prev_cr = cr;
        prev_l  = el;
        prev_cl = cl;
    endtask

    initial begin
        logic [IV_W-1:0] iv;
        logic [WV_W-1:0] wv;
        logic [BV_W-1:0] bv;
        logic [AV_W-1:0] er, el;
        logic [1:0]      cr, cl;

        spec_w = '{
            '{0, 0, 2, -3, -1, -4, -1, 0, -5, 1, 3, 1, -1, 1, -1, 2, -3, 2, -4, 2, -3},
            '{34, -23, 4, -19, 11, -19, 41, 56, 19, 30, 35, -1, -30, -36, -73, 63, -89, -36, -50, 60, -12},
            '{11, 68, -17, 16, 5, 33, 7, -30, -25, -25, 27, 58, 13, -52, -27, 1, 39, -93, -17, -22, -9}
        };

        tbl[0] = '{"spec_zero_in", '0, pack_w(spec_w), pb3(-73, 748, 1077),
                   pk3(0, 748, 1077), 2'd2, pk3(-73, 748, 1077), 2'd2, 10};
        tbl[1] = '{"spec_all15", {N_IN{4'hF}}, pack_w(spec_w), pb3(-73, 748, 1077),
                   pk3(0, 223, 492), 2'd2, pk3(-253, 223, 492), 2'd2, 1};
        tbl[2] = '{"zero_w_tie", {N_IN{4'h9}}, '0, pb3(-5, -5, -5),
                   pk3(0, 0, 0), 2'd0, pk3(-5, -5, -5), 2'd0, 0};
        tbl[3] = '{"zero_w_mid", {N_IN{4'h3}}, '0, pb3(-5, 7, 7),
                   pk3(0, 7, 7), 2'd1, pk3(-5, 7, 7), 2'd1, 2};
        tbl[4] = '{"tie_0_2", '0, pack_w(spec_w), pb3(100, -20, 100),
                   pk3(100, 0, 100), 2'd0, pk3(100, -20, 100), 2'd0, 0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inp       = '0;
        weights   = '0;
        bias      = '0;
        prev_r    = '0;
        prev_l    = '0;
        prev_cr   = '0;
        prev_cl   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_flags", {in_ready_r, out_valid_r, in_ready_l, out_valid_l}, 4'b1010);
        chk("reset_outputs", {out_act_r, out_class_r, out_act_l, out_class_l}, '0);

        for (int i = 0; i < 5; i++)
            run_txn(tbl[i].name, tbl[i].iv, tbl[i].wv, tbl[i].bv,
                    tbl[i].exp_r, tbl[i].cls_r, tbl[i].exp_l, tbl[i].cls_l, tbl[i].hold);

        // Abort a transaction with reset partway through MAC, then rerun the reference vector.
        @(negedge clk);
        inp      = tbl[1].iv;
        weights  = tbl[1].wv;
        bias     = tbl[1].bv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_flags", {in_ready_r, out_valid_r, in_ready_l, out_valid_l}, 4'b1010);
        chk("abort_cleared", {out_act_r, out_class_r, out_act_l, out_class_l}, '0);
        prev_r  = '0;
        prev_l  = '0;
        prev_cr = '0;
        prev_cl = '0;
        run_txn("after_abort", tbl[0].iv, tbl[0].wv, tbl[0].bv,
                tbl[0].exp_r, tbl[0].cls_r, tbl[0].exp_l, tbl[0].cls_l, 0);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < N_IN; k++)
                iv[k*IN_W +: IN_W] = (t % 5 == 0) ? 4'hF : IN_W'($urandom);
            for (int w = 0; w < N_OUT * N_IN; w++)
                wv[w*W_W +: W_W] = W_W'($urandom);
            for (int n = 0; n < N_OUT; n++)
                bv[n*B_W +: B_W] = (t % 3 == 0) ? B_W'($urandom_range(0, 200) - 100) : B_W'($urandom);
            model(iv, wv, bv, 1'b1, er, cr);
            model(iv, wv, bv, 1'b0, el, cl);
            run_txn($sformatf("rand%0d", t), iv, wv, bv, er, cr, el, cl, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
